// File: rtl/event_toggle_tx.sv
// event_toggle_tx: converts overflow/underflow event pulses into paced toggle levels for a clock-domain crossing.
module event_toggle_tx #(
  parameter int HOLDOFF = 3,
  parameter int CNT_W = 4
) (
  input  logic             FIFO_CLK,
  input  logic             NRST,
  input  logic             FIFO_OVERFLOW_EVT,
  input  logic             FIFO_UNDERFLOW_EVT,
  input  logic             CLR_LOST,
  output logic             FIFO_OVERFLOW,
  output logic             FIFO_UNDERFLOW,
  output logic [CNT_W-1:0] OVF_PENDING,
  output logic [CNT_W-1:0] UDF_PENDING,
  output logic             OVF_LOST,
  output logic             UDF_LOST,
  output logic             BUSY
);
  if (HOLDOFF < 2 || HOLDOFF > 15 || CNT_W < 2 || CNT_W > 8) begin : g_bad_param
    $error("event_toggle_tx: HOLDOFF must be 2..15 and CNT_W 2..8");
  end
  logic [1:0] evt;
  assign evt = {FIFO_UNDERFLOW_EVT, FIFO_OVERFLOW_EVT};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic             tog, lost, fire, drop;
    logic [CNT_W-1:0] pend;
    logic [3:0]       hold;
    assign fire = (hold == 4'd0) && (pend != '0 || evt[c]);
    // a saturated counter holds and the event is dropped instead of wrapping
    assign drop = evt[c] && !fire && (&pend);
    always_ff @(posedge FIFO_CLK or negedge NRST) begin
      if (!NRST) begin
        tog  <= 1'b0;
        lost <= 1'b0;
        pend <= '0;
        hold <= 4'd0;
      end else begin
        tog  <= tog ^ fire;
        hold <= fire ? 4'(HOLDOFF) : hold - 4'(hold != 4'd0);
        pend <= drop ? pend : pend + CNT_W'(evt[c]) - CNT_W'(fire);
        lost <= drop | (lost & ~CLR_LOST);
      end
    end
  end
  assign FIFO_OVERFLOW  = g_ch[0].tog;
  assign FIFO_UNDERFLOW = g_ch[1].tog;
  assign OVF_PENDING    = g_ch[0].pend;
  assign UDF_PENDING    = g_ch[1].pend;
  assign OVF_LOST       = g_ch[0].lost;
  assign UDF_LOST       = g_ch[1].lost;
  assign BUSY = |{g_ch[0].pend, g_ch[1].pend, g_ch[0].hold, g_ch[1].hold};
endmodule

// File: tb/tb_event_toggle_tx.sv
// tb_event_toggle_tx: directed checks of event_toggle_tx with HOLDOFF=3, CNT_W=4.
module tb_event_toggle_tx;
  logic clk = 1'b0, nrst, ovf, udf, clr;
  logic ovf_t, udf_t, ovf_l, udf_l, busy;
  logic [3:0] ovf_p, udf_p;
  int n_checks = 0, n_pass = 0, flips;
  logic prev;

  event_toggle_tx #(.HOLDOFF(3), .CNT_W(4)) dut (
    .FIFO_CLK(clk), .NRST(nrst), .FIFO_OVERFLOW_EVT(ovf), .FIFO_UNDERFLOW_EVT(udf),
    .CLR_LOST(clr), .FIFO_OVERFLOW(ovf_t), .FIFO_UNDERFLOW(udf_t), .OVF_PENDING(ovf_p),
    .UDF_PENDING(udf_p), .OVF_LOST(ovf_l), .UDF_LOST(udf_l), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick_count;
    tick;
    if (ovf_t !== prev) flips++;
    prev = ovf_t;
  endtask

  initial begin
    nrst = 1'b0; ovf = 1'b0; udf = 1'b0; clr = 1'b0;
    tick; tick;
    chk("reset_outputs", {ovf_t, udf_t, ovf_p, udf_p, ovf_l, udf_l, busy}, 16'h0);
    nrst = 1'b1;
    // single pulse in the first cycle after release
    ovf = 1'b1; tick; ovf = 1'b0;
    chk("single_tog", ovf_t, 1);
    chk("single_busy_e1", busy, 1);
    chk("single_pend", ovf_p, 0);
    chk("single_udf_tog", udf_t, 0);
    tick; chk("single_busy_e2", busy, 1);
    tick; chk("single_busy_e3", busy, 1);
    tick; chk("single_busy_e4", busy, 0);
    // three back-to-back pulses
    ovf = 1'b1; tick;
    chk("three_e1_tog", ovf_t, 0); chk("three_e1_pend", ovf_p, 0);
    tick; chk("three_e2_pend", ovf_p, 1);
    tick; chk("three_e3_pend", ovf_p, 2);
    ovf = 1'b0;
    tick; chk("three_e4_tog", ovf_t, 0); chk("three_e4_pend", ovf_p, 2);
    tick; chk("three_e5_tog", ovf_t, 1); chk("three_e5_pend", ovf_p, 1);
    tick; tick; tick; chk("three_e8_tog", ovf_t, 1); chk("three_e8_pend", ovf_p, 1);
    tick; chk("three_e9_tog", ovf_t, 0); chk("three_e9_pend", ovf_p, 0);
    tick; tick; tick; chk("three_e12_busy", busy, 0);
    // 24 consecutive events saturate the counter
    flips = 0; prev = ovf_t;
    for (int i = 0; i < 24; i++) begin
      ovf = 1'b1;
      tick_count;
      if (i == 19) chk("sat_e20_pend", ovf_p, 15);
      if (i == 20) chk("sat_e21_lost", ovf_l, 0);
      if (i == 21) chk("sat_e22_lost", ovf_l, 1);
      if (i == 23) chk("sat_e24_pend", ovf_p, 15);
    end
    ovf = 1'b0;
    repeat (70) tick_count;
    chk("sat_flips", 16'(flips), 21);
    chk("sat_final_tog", ovf_t, 1);
    chk("sat_drained", {ovf_p, busy}, 0);
    chk("sat_lost_sticky", ovf_l, 1);
    chk("sat_udf_untouched", {udf_t, udf_p, udf_l}, 0);
    // clear alone, then clear coinciding with a drop
    clr = 1'b1; tick; clr = 1'b0;
    chk("clr_alone", ovf_l, 0);
    ovf = 1'b1;
    repeat (23) tick;
    chk("resat_lost", ovf_l, 1);
    clr = 1'b1; tick;
    chk("clr_vs_drop_lost", ovf_l, 1);
    chk("clr_vs_drop_pend", ovf_p, 15);
    ovf = 1'b0; tick; clr = 1'b0;
    chk("clr_after_drop", ovf_l, 0);
    repeat (70) tick;
    chk("resat_final_tog", ovf_t, 0);
    // mid-operation asynchronous reset with pending=5, toggle=1
    ovf = 1'b1; tick; ovf = 1'b0;
    repeat (4) tick;
    ovf = 1'b1; repeat (7) tick; ovf = 1'b0;
    chk("pre_rst_pend", ovf_p, 5);
    chk("pre_rst_tog", ovf_t, 1);
    #2 nrst = 1'b0;
    #1 chk("async_rst_outputs", {ovf_t, udf_t, ovf_p, udf_p, ovf_l, udf_l, busy}, 16'h0);
    tick; nrst = 1'b1;
    flips = 0; prev = ovf_t;
    repeat (10) tick_count;
    chk("post_rst_no_flips", 16'(flips), 0);
    chk("post_rst_idle", {ovf_t, ovf_p, busy}, 0);
    // independent channels
    ovf = 1'b1; udf = 1'b1; tick; ovf = 1'b0; udf = 1'b0;
    chk("dual_e1_tog", {ovf_t, udf_t}, 2'b11);
    tick; udf = 1'b1; tick; udf = 1'b0;
    chk("dual_e3_udf_pend", udf_p, 1);
    chk("dual_e3_ovf_pend", ovf_p, 0);
    tick; chk("dual_e4_udf_tog", udf_t, 1);
    tick; chk("dual_e5_tog", {ovf_t, udf_t}, 2'b10);
    chk("dual_e5_udf_pend", udf_p, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
